fetch_sequencer: RTL

- Parametrised instruction-fetch and program-counter unit for the next-generation MIPS core.
- Replaces the ad-hoc PC register, PC+4 adder and branch mux with a single sequential block.
- Issues one instruction fetch at a time to instruction memory through a req/ack handshake.
- Holds each fetched instruction for the decode stage through a valid/ready handshake, then computes the next PC from branch, jump or jump-register redirects.

---
 rtl/fetch_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch / program-counter sequencer: one outstanding fetch, a held decode slot and next-PC redirect.
// Optional MIPS branch delay slot enabled by defining FETCH_DELAY_SLOT_EN.
module fetch_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter int                INSTR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_plus4,
    input  logic               branch_taken,
    input  logic [15:0]        branch_imm,
    input  logic               jump_en,
    input  logic [25:0]        jump_target,
    input  logic               jr_en,
    input  logic [ADDR_W-1:0]  jr_addr,
    output logic               misalign
);

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_ISSUE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_instr;
    logic                r_misalign;
    logic [ADDR_W-1:0]   w_pc_plus4;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [ADDR_W-1:0]   w_redir_tgt;
    logic                w_redir;
    logic                w_jr_mis;
    logic                w_mis_set;
    logic                w_req;
    logic                w_valid;
    logic                w_capture;
    logic                w_consume;

    function automatic logic [ADDR_W-1:0] f_branch_tgt(input logic [ADDR_W-1:0] base,
                                                       input logic signed [15:0] imm);
        logic signed [ADDR_W-1:0] off;
        off = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
        return base + $unsigned(off);
    endfunction

    // Jump keeps the top bits above the 256 MB region of the delay-slot address.
    function automatic logic [ADDR_W-1:0] f_jump_tgt(input logic [ADDR_W-1:0] base,
                                                     input logic [25:0]       tgt);
        return (base & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({tgt, 2'b00});
    endfunction

    assign w_pc_plus4 = r_pc + ADDR_W'(4);

    always_comb begin
        w_redir     = 1'b1;
        w_redir_tgt = w_pc_plus4;
        w_jr_mis    = 1'b0;
        if (jr_en) begin
            w_redir_tgt = {jr_addr[ADDR_W-1:2], 2'b00};
            w_jr_mis    = |jr_addr[1:0];
        end else if (jump_en) begin
            w_redir_tgt = f_jump_tgt(w_pc_plus4, jump_target);
        end else if (branch_taken) begin
            w_redir_tgt = f_branch_tgt(w_pc_plus4, branch_imm);
        end else begin
            w_redir = 1'b0;
        end
    end

`ifdef FETCH_DELAY_SLOT_EN
    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_tgt;

    // The instruction after a redirect always executes; the stored target applies when it is consumed.
    assign w_pc_nxt  = r_pend ? r_pend_tgt : w_pc_plus4;
    assign w_mis_set = w_consume & ~r_pend & w_jr_mis;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= 1'b0;
        end else if (w_consume) begin
            if (r_pend) begin
                r_pend <= 1'b0;
            end else if (w_redir) begin
                r_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_consume && !r_pend && w_redir) begin
            r_pend_tgt <= w_redir_tgt;
        end
    end
`else
    assign w_pc_nxt  = w_redir_tgt;
    assign w_mis_set = w_consume & w_jr_mis;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_valid     = 1'b0;
        w_capture   = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_req = 1'b1;
                if (imem_ack) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_valid = 1'b1;
                if (instr_ready) begin
                    w_consume   = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_VEC;
            r_instr    <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
            if (w_consume) begin
                r_pc <= w_pc_nxt;
            end
            if (w_mis_set) begin
                r_misalign <= 1'b1;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign imem_req    = w_req;
    assign instr_out   = r_instr;
    assign instr_valid = w_valid;
    assign pc_out      = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign misalign    = r_misalign;

endmodule
